// File: rtl/arm_mem_arbiter.sv
// ---------------------------------------------------------------------------
// arm_mem_arbiter
//
// Shares the core's single word-addressed memory port between the instruction
// fetch requester (if_*) and the load/store requester (ls_*). One transaction
// is in flight at a time. The memory request is held until mem_ack, and read
// data is returned to whichever requester owns the transaction. Load/store
// has fixed priority. A streak counter lets fetch in after FAIR_LIMIT
// consecutive LS grants that were made while fetch was waiting.
//
// Optional feature macro: ARM_ARB_TIMEOUT_EN
//   When defined, a BUSY transaction that sees no mem_ack within TIMEOUT
//   cycles is aborted. The owner gets rvalid with rdata 32'hDEADBEEF (0 for
//   stores) and arb_err pulses. When undefined, BUSY waits indefinitely and
//   arb_err is tied low.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   halt                blocks new grants; an in-flight transaction completes
//   if_req/if_addr      fetch request (level) and word address
//   if_gnt              fetch accepted (1-cycle pulse)
//   if_rvalid/if_rdata  fetch data pulse / data (held until next if_rvalid)
//   ls_req/ls_we/ls_addr/ls_wdata  load/store request, 1 = store
//   ls_gnt              LS accepted (1-cycle pulse)
//   ls_rvalid/ls_rdata  LS completion pulse / load data (0 for stores)
//   mem_req/mem_we/mem_addr/mem_wdata  memory request, held until mem_ack
//   mem_ack/mem_rdata   memory completion; read data valid in the same cycle
//   arb_idle            arbiter is in IDLE
//   arb_err             timeout abort pulse
//
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module arm_mem_arbiter #(
  parameter int ADDR_W     = 30,
  parameter int DATA_W     = 32,
  parameter int FAIR_LIMIT = 3,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              arb_idle,
  output logic              arb_err
);

  localparam int STREAK_W = (FAIR_LIMIT > 0) ? $clog2(FAIR_LIMIT + 1) : 1;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(FAIR_LIMIT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_LS = 2'd2
  } state_t;

  // Saturating increment for the fairness streak.
  function automatic logic [STREAK_W-1:0] streak_sat_inc(input logic [STREAK_W-1:0] s);
    return (s >= STREAK_MAX) ? s : s + STREAK_W'(1);
  endfunction

  state_t              state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;

  logic                mem_req_d, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_d;
  logic                if_gnt_d, ls_gnt_d;
  logic                if_rvalid_d, ls_rvalid_d;
  logic [DATA_W-1:0]   if_rdata_d, ls_rdata_d;
  logic                arb_idle_d;
  logic                ls_wins;

`ifdef ARM_ARB_TIMEOUT_EN
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] ABORT_DATA = DATA_W'(32'hDEADBEEF);

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              arb_err_d;
`endif

  // LS wins whenever it asks, unless fetch is also waiting and has already
  // been passed over FAIR_LIMIT times in a row.
  assign ls_wins    = ls_req && !(if_req && (streak_q == STREAK_MAX));
  assign arb_idle_d = (state_d == IDLE);

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    if_gnt_d    = 1'b0;
    ls_gnt_d    = 1'b0;
    if_rvalid_d = 1'b0;
    ls_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata;
    ls_rdata_d  = ls_rdata;
`ifdef ARM_ARB_TIMEOUT_EN
    wait_d      = wait_q;
    arb_err_d   = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (!halt) begin
          if (ls_wins) begin
            state_d     = BUSY_LS;
            mem_req_d   = 1'b1;
            mem_we_d    = ls_we;
            mem_addr_d  = ls_addr;
            mem_wdata_d = ls_wdata;
            ls_gnt_d    = 1'b1;
            // The streak only grows while fetch is actually being held off.
            streak_d    = if_req ? streak_sat_inc(streak_q) : '0;
`ifdef ARM_ARB_TIMEOUT_EN
            wait_d      = '0;
`endif
          end else if (if_req) begin
            state_d     = BUSY_IF;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            if_gnt_d    = 1'b1;
            streak_d    = '0;
`ifdef ARM_ARB_TIMEOUT_EN
            wait_d      = '0;
`endif
          end
        end
      end

      BUSY_IF: begin
        if (mem_ack) begin
          state_d     = IDLE;
          mem_req_d   = 1'b0;
          if_rvalid_d = 1'b1;
          if_rdata_d  = mem_rdata;
        end
`ifdef ARM_ARB_TIMEOUT_EN
        else if (wait_q == WAIT_LAST) begin
          state_d     = IDLE;
          mem_req_d   = 1'b0;
          if_rvalid_d = 1'b1;
          if_rdata_d  = ABORT_DATA;
          arb_err_d   = 1'b1;
        end else begin
          wait_d      = wait_q + WAIT_W'(1);
        end
`endif
      end

      BUSY_LS: begin
        if (mem_ack) begin
          state_d     = IDLE;
          mem_req_d   = 1'b0;
          ls_rvalid_d = 1'b1;
          ls_rdata_d  = mem_we ? '0 : mem_rdata;
        end
`ifdef ARM_ARB_TIMEOUT_EN
        else if (wait_q == WAIT_LAST) begin
          state_d     = IDLE;
          mem_req_d   = 1'b0;
          ls_rvalid_d = 1'b1;
          ls_rdata_d  = mem_we ? '0 : ABORT_DATA;
          arb_err_d   = 1'b1;
        end else begin
          wait_d      = wait_q + WAIT_W'(1);
        end
`endif
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any transaction silently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      streak_q  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_gnt    <= 1'b0;
      ls_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      if_rdata  <= '0;
      ls_rdata  <= '0;
      arb_idle  <= 1'b1;
    end else begin
      state_q   <= state_d;
      streak_q  <= streak_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      if_gnt    <= if_gnt_d;
      ls_gnt    <= ls_gnt_d;
      if_rvalid <= if_rvalid_d;
      ls_rvalid <= ls_rvalid_d;
      if_rdata  <= if_rdata_d;
      ls_rdata  <= ls_rdata_d;
      arb_idle  <= arb_idle_d;
    end
  end

`ifdef ARM_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_q  <= '0;
      arb_err <= 1'b0;
    end else begin
      wait_q  <= wait_d;
      arb_err <= arb_err_d;
    end
  end
`else
  assign arb_err = 1'b0;
`endif

endmodule

// File: doc/arm_mem_arbiter.md
# arm_mem_arbiter

Sequential arbiter that shares the core's single word-addressed memory port between the instruction-fetch requester and the load/store requester. It sits between the core's fetch/LS logic and the external memory. It serialises one transaction at a time, holds the memory request until acknowledged, and returns read data to the owning requester. Load/store has fixed priority, with a fairness override so fetch cannot starve.

## Interface
Parameters:
- ADDR_W, 30, word address width (byte address bits [1:0] implicitly zero)
- DATA_W, 32, data width
- FAIR_LIMIT, 3, consecutive LS grants allowed while fetch waits
- TIMEOUT, 255, cycles to wait for mem_ack before abort (used only with ARM_ARB_TIMEOUT_EN)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-low reset
- halt  input  1  block new grants; in-flight transaction completes
- if_req  input  1  fetch request, level
- if_addr  input  ADDR_W  fetch word address
- if_gnt  output  1  fetch request accepted, 1-cycle pulse
- if_rvalid  output  1  fetch data valid, 1-cycle pulse
- if_rdata  output  DATA_W  fetch data
- ls_req  input  1  load/store request, level
- ls_we  input  1  1 = store, 0 = load
- ls_addr  input  ADDR_W  LS word address
- ls_wdata  input  DATA_W  store data
- ls_gnt  output  1  LS request accepted, 1-cycle pulse
- ls_rvalid  output  1  LS completion pulse (loads and stores)
- ls_rdata  output  DATA_W  load data; 0 for stores
- mem_req  output  1  memory request, held until mem_ack
- mem_we  output  1  memory write enable
- mem_addr  output  ADDR_W  memory word address
- mem_wdata  output  DATA_W  memory write data
- mem_ack  input  1  memory completion; mem_rdata valid same cycle
- mem_rdata  input  DATA_W  memory read data
- arb_idle  output  1  state is IDLE
- arb_err  output  1  timeout abort pulse

## Operation
- FSM states: IDLE, BUSY_IF, BUSY_LS.
- Requests are sampled only in IDLE. They are ignored in the BUSY states.
- IDLE with halt=0:
  - ls_req only -> BUSY_LS.
  - if_req only -> BUSY_IF.
  - both -> BUSY_LS, unless streak==FAIR_LIMIT, then BUSY_IF.
- IDLE with halt=1: stay IDLE.
- On transition into BUSY: register mem_req=1, mem_addr, mem_we (0 for fetch), mem_wdata, and pulse the owner's gnt.
- BUSY_x with mem_ack=1: clear mem_req, pulse x_rvalid, register x_rdata (mem_rdata for reads, 0 for stores), go to IDLE.
- streak counter, width $clog2(FAIR_LIMIT+1):
  - increments on an LS grant while if_req=1;
  - clears on an IF grant, or on an LS grant while if_req=0;
  - saturates at FAIR_LIMIT.
- Requester rules:
  - Hold req, addr, we, and wdata stable until gnt.
  - Deassert req in the gnt cycle.
  - Present no new request before its rvalid.
- x_rdata holds its value until the next rvalid for x.
- Outputs are fully registered. There is no combinational path from inputs to outputs.
- Reset (any time, including mid-transaction): asynchronously forces
  - state IDLE, streak 0;
  - mem_req, mem_we, all gnt/rvalid, arb_err = 0;
  - addr/data outputs = 0;
  - arb_idle = 1.
  - The aborted transaction produces no rvalid.

## Timing
- Request high in IDLE at cycle N -> mem_req and gnt high at N+1.
- mem_ack at cycle M (M ≥ N+1; zero-wait memory asserts ack at N+1):
  - mem_req low, rvalid high, and state IDLE at M+1;
  - a new request can be sampled at M+1, giving mem_req at M+2.
- Peak throughput: one transaction per 2 cycles.
- mem_ack outside BUSY is ignored.
- halt rising during BUSY does not affect that transaction.

## Configuration
- ARM_ARB_TIMEOUT_EN defined:
  - A wait counter resets on each BUSY entry and increments each BUSY cycle without mem_ack.
  - If the count reaches TIMEOUT without ack: clear mem_req, pulse owner rvalid with rdata=32'hDEADBEEF (stores: 0), pulse arb_err, go to IDLE.
  - If mem_ack arrives in the same cycle as expiry, the ack wins.
- Not defined: no counter; BUSY waits indefinitely; arb_err tied 0.

## Test plan
- Reset, then fetch only: if_req, if_addr=30'h10, zero-wait memory, mem_rdata=32'hE3A00001 -> mem_req/if_gnt at N+1, if_rvalid at N+2 with if_rdata=32'hE3A00001.
- Simultaneous requests, both held continuously, FAIR_LIMIT=3 -> grant order LS, LS, LS, IF, LS, LS, LS, IF; no fetch wait exceeds 4 transactions.
- Store then load with 3-cycle ack latency: ls_we=1, addr 30'h40, wdata 32'hCAFEF00D -> mem_req held 3 cycles with mem_we=1, ls_rvalid with ls_rdata=0. Then load of 30'h40 returns 32'hCAFEF00D.
- Reset asserted two cycles into a pending BUSY_LS -> mem_req drops immediately (async), no ls_rvalid, arb_idle=1. After release, a new if_req is granted normally.
- halt=1 with if_req high for 10 cycles -> no gnt, arb_idle=1. halt low -> if_gnt next cycle.
- ARM_ARB_TIMEOUT_EN, TIMEOUT=8, mem_ack never asserted on a load -> arb_err and ls_rvalid at cycle 8 after BUSY entry, ls_rdata=32'hDEADBEEF, mem_req low, state IDLE.
